player_input_scheduler: RTL

//  Sequences keyboard input into per-frame player move commands for game_logic. Queues PS/2 make/break

---
 rtl/input_sched_pkg.sv | 16 +
 rtl/ps2_event_fifo.sv | 37 +++
 rtl/player_input_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/input_sched_pkg.sv
// input_sched_pkg: shared direction/state types, keycodes and direction priority helper
package input_sched_pkg;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {IDLE, SCAN, WRITE} sched_state_t;
  localparam logic [7:0] PS2_W = 8'h1D;
  localparam logic [7:0] PS2_D = 8'h23;
  localparam logic [7:0] PS2_S = 8'h1B;
  localparam logic [7:0] PS2_A = 8'h1C;
  localparam logic [7:0] HID_UP = 8'h52;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_DOWN = 8'h51;
  localparam logic [7:0] HID_LEFT = 8'h50;
  function automatic dir_t pick_dir(input logic [3:0] h);
    return h[0] ? DIR_UP : h[1] ? DIR_RIGHT : h[2] ? DIR_DOWN : h[3] ? DIR_LEFT : DIR_UP;
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: {make,code} event queue with full/empty and drop-on-full strobe
module ps2_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [8:0] din,
  output logic [8:0] dout,
  output logic       full,
  output logic       empty,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);
  logic [8:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_pop, do_push;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop = push & ~do_push;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/player_input_scheduler.sv
// player_input_scheduler: PS/2 held-key table + USB keycodes -> per-frame player moves; INPUT_SCHED_HOLDOFF_EN enables move repeat holdoff
module player_input_scheduler
  import input_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NSLOTS = 4,
  parameter int HOLDOFF_FRAMES = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic [7:0]          ps2_code,
  input  logic                ps2_valid,
  input  logic                ps2_make,
  input  logic [31:0]         usb_keycode,
  output logic                p1_move,
  output logic [1:0]          p1_dir,
  output logic                p2_move,
  output logic [1:0]          p2_dir,
  output logic [8*NSLOTS-1:0] held_keys,
  output logic                overflow
);
  localparam int IW = $clog2(NSLOTS);
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 || NSLOTS < 2 || HOLDOFF_FRAMES < 1) begin : g_bad_param
    $error("player_input_scheduler: illegal parameter set");
  end
  sched_state_t state, state_nx;
  logic [8:0] fd, ev;
  logic fempty, ffull, fdrop, pop;
  logic [IW-1:0] idx, midx, eidx;
  logic match_f, empty_f;
  logic [7:0] slot [NSLOTS];
  logic [2:0] fsync;
  logic tick;
  logic [3:0] h1, h2;
  logic [1:0] any, mv;
  dir_t nd [2];
  dir_t dr [2];
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk),
    .rst(Reset),
    .push(ps2_valid),
    .pop(pop),
    .din({ps2_make, ps2_code}),
    .dout(fd),
    .full(ffull),
    .empty(fempty),
    .drop(fdrop)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsync <= '0;
      tick <= 1'b0;
    end else begin
      fsync <= {fsync[1:0], frame_clk};
      tick <= fsync[1] & ~fsync[2];
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = ~fempty;
        state_nx = fempty ? IDLE : SCAN;
      end
      SCAN: state_nx = (idx == IW'(NSLOTS - 1)) ? WRITE : SCAN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ev <= '0;
      idx <= '0;
      midx <= '0;
      eidx <= '0;
      match_f <= 1'b0;
      empty_f <= 1'b0;
      overflow <= 1'b0;
      for (int s = 0; s < NSLOTS; s++) slot[s] <= '0;
    end else begin
      if (fdrop) overflow <= 1'b1;
      case (state)
        IDLE: if (pop) begin
          ev <= fd;
          idx <= '0;
          match_f <= 1'b0;
          empty_f <= 1'b0;
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (!match_f && ev[7:0] != 8'h00 && slot[idx] == ev[7:0]) begin
            match_f <= 1'b1;
            midx <= idx;
          end
          if (!empty_f && slot[idx] == 8'h00) begin
            empty_f <= 1'b1;
            eidx <= idx;
          end
        end
        WRITE: if (ev[7:0] != 8'h00) begin
          if (ev[8] && !match_f && empty_f) slot[eidx] <= ev[7:0];
          if (ev[8] && !match_f && !empty_f) overflow <= 1'b1;
          if (!ev[8] && match_f) slot[midx] <= 8'h00;
        end
        default: ;
      endcase
    end
  end
  for (genvar i = 0; i < NSLOTS; i++) begin : g_held
    assign held_keys[8*i +: 8] = slot[i];
  end
  always_comb begin
    h1 = '0;
    h2 = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      h1 |= {slot[s] == PS2_A, slot[s] == PS2_S, slot[s] == PS2_D, slot[s] == PS2_W};
    end
    for (int b = 0; b < 4; b++) begin
      h2 |= {usb_keycode[8*b +: 8] == HID_LEFT, usb_keycode[8*b +: 8] == HID_DOWN,
             usb_keycode[8*b +: 8] == HID_RIGHT, usb_keycode[8*b +: 8] == HID_UP};
    end
    any = {|h2, |h1};
    nd[0] = pick_dir(h1);
    nd[1] = pick_dir(h2);
  end
`ifdef INPUT_SCHED_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
  logic [HW-1:0] cnt [2];
  logic [1:0] active;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mv <= '0;
      active <= '0;
      for (int p = 0; p < 2; p++) begin
        dr[p] <= DIR_UP;
        cnt[p] <= '0;
      end
    end else begin
      mv <= '0;
      for (int p = 0; p < 2; p++) begin
        if (tick && any[p]) begin
          active[p] <= 1'b1;
          if (!active[p] || nd[p] != dr[p] || cnt[p] == HW'(HOLDOFF_FRAMES - 1)) begin
            mv[p] <= 1'b1;
            dr[p] <= nd[p];
            cnt[p] <= '0;
          end else cnt[p] <= cnt[p] + 1'b1;
        end else if (tick) begin
          active[p] <= 1'b0;
          cnt[p] <= '0;
        end
      end
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mv <= '0;
      for (int p = 0; p < 2; p++) dr[p] <= DIR_UP;
    end else begin
      mv <= tick ? any : 2'b00;
      for (int p = 0; p < 2; p++) if (tick && any[p]) dr[p] <= nd[p];
    end
  end
`endif
  assign p1_move = mv[0];
  assign p2_move = mv[1];
  assign p1_dir = dr[0];
  assign p2_dir = dr[1];
endmodule
